// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One extra bit keeps MAX_BURST-1 representable even when MAX_BURST is 1.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the last grant wins.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  win,
  output logic             any
);

  int   idx;
  logic found;

  // Modulo scan so non-power-of-2 N_REQ never lands on a missing index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; words tagged with source id.
//   state | meaning
//   IDLE  | no grant, all s_ready low, picking next winner
//   BUSY  | grant_rg owns the write port for up to MAX_BURST beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         s_valid,
  input  logic [N_REQ*DATA_W-1:0]  s_data,
  output logic [N_REQ-1:0]         s_ready,
  output logic                     fifo_wren,
  output logic [ID_W+DATA_W-1:0]   fifo_wrdata,
  input  logic                     fifo_full,
  output logic                     o_busy,
  output logic [ID_W-1:0]          o_grant_id
);

  localparam int                BEAT_W    = beat_width(MAX_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_REQ - 1);

  state_e            state_rg;
  logic [ID_W-1:0]   grant_rg;
  logic [ID_W-1:0]   last_rg;
  logic [BEAT_W-1:0] beat_rg;
  logic [ID_W-1:0]   pick;
  logic              any_req;
  logic              busy;
  logic              g_valid;
  logic              xfer;
  logic              release_now;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (s_valid),
    .last (last_rg),
    .win  (pick),
    .any  (any_req)
  );

  assign busy    = (state_rg == BUSY);
  assign g_valid = s_valid[grant_rg];
  assign xfer    = busy & g_valid & !fifo_full;
  // A low valid ends the grant even while stalled on a full FIFO.
  assign release_now = busy & (!g_valid | (xfer & (beat_rg == LAST_BEAT)));

  always_comb begin
    s_ready = '0;
    if (busy && !fifo_full) s_ready[grant_rg] = 1'b1;
  end

  assign fifo_wren   = xfer;
  assign fifo_wrdata = {grant_rg, s_data[int'(grant_rg)*DATA_W +: DATA_W]};
  assign o_busy      = busy;
  assign o_grant_id  = grant_rg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_rg <= IDLE;
      grant_rg <= '0;
      last_rg  <= LAST_IDX;
      beat_rg  <= '0;
    end else begin
      case (state_rg)
        IDLE: begin
          if (any_req) begin
            state_rg <= BUSY;
            grant_rg <= pick;
            beat_rg  <= '0;
          end
        end
        BUSY: begin
          if (xfer) beat_rg <= beat_rg + BEAT_W'(1);
          if (release_now) begin
            state_rg <= IDLE;
            last_rg  <= grant_rg;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomised bench for fifo_wr_arbiter with a depth-8 FIFO model behind it.
module tb_fifo_wr_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;
  localparam int FW     = ID_W + DATA_W;
  localparam int DEPTH  = 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ*DATA_W-1:0] s_data;
  logic [N_REQ-1:0]        s_ready;
  logic                    fifo_wren;
  logic [FW-1:0]           fifo_wrdata;
  logic                    fifo_full;
  logic                    o_busy;
  logic [ID_W-1:0]         o_grant_id;

  logic          fifo_rd;
  logic          fifo_clr;
  logic [FW-1:0] fq[$];
  int            fq_cnt = 0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] base[N_REQ];
  int          cnt[N_REQ];

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .fifo_wren   (fifo_wren),
    .fifo_wrdata (fifo_wrdata),
    .fifo_full   (fifo_full),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id)
  );

  // FIFO model: full is a zero-latency status of the registered occupancy
  assign fifo_full = (fq_cnt >= DEPTH);

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wren) fq.push_back(fifo_wrdata);
    end
    fq_cnt <= fq.size();
  end

  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) s_data[i*DATA_W +: DATA_W] = base[i] + DATA_W'(cnt[i]);
  endtask

  // Producers advance their payload only on an accepted beat.
  task automatic step();
    logic [N_REQ-1:0] acc;
    acc = s_valid & s_ready & {N_REQ{rstn}};
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) if (acc[i]) cnt[i]++;
    drive_data();
  endtask

  task automatic reset_all();
    rstn     = 1'b0;
    s_valid  = '0;
    fifo_rd  = 1'b0;
    fifo_clr = 1'b1;
    for (int i = 0; i < N_REQ; i++) cnt[i] = 0;
    drive_data();
    step();
    rstn     = 1'b1;
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h0;
    base[0] = 32'h1122_3344;
    reset_all();
    #1;
    n_vec++;
    if (s_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", s_ready); end
    n_vec++;
    if (fifo_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", fifo_wren); end
    n_vec++;
    if (fifo_wrdata !== {2'd0, 32'h1122_3344}) begin
      n_err++; $display("FAIL reset_wrdata: got %h want %h", fifo_wrdata, {2'd0, 32'h1122_3344});
    end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_vec++;
    if (o_grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", o_grant_id); end
  endtask

  task automatic test_single_requester();
    logic [7:0]      exp_busy;
    logic [ID_W+1:0] obs, expv;
    exp_busy = 8'b1101_1110;
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h0;
    base[2] = 32'hA0;
    reset_all();
    s_valid = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      #1;
      obs  = {o_busy, fifo_wren, o_grant_id};
      expv = {exp_busy[c], exp_busy[c], (c == 0) ? 2'd0 : 2'd2};
      n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL single_c%0d: busy/wren/gid got %b want %b", c, obs, expv); end
      step();
      if (cnt[2] == 6) s_valid = 4'b0000;
    end
    step();
    #1;
    n_vec++;
    if (fq.size() != 6) begin n_err++; $display("FAIL single_count: got %0d want 6", fq.size()); end
    for (int i = 0; i < 6 && i < fq.size(); i++) begin
      n_vec++;
      if (fq[i] !== {2'd2, 32'hA0 + 32'(i)}) begin
        n_err++; $display("FAIL single_word%0d: got %h want %h", i, fq[i], {2'd2, 32'hA0 + 32'(i)});
      end
    end
  endtask

  task automatic test_saturated();
    logic            eb;
    logic [ID_W-1:0] eg;
    logic [ID_W+1:0] obs, expv;
    logic [31:0]     ep;
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h100 * i;
    reset_all();
    s_valid = 4'b1111;
    fifo_rd = 1'b1;
    for (int c = 0; c < 25; c++) begin
      #1;
      eb = (c % 5) != 0;
      if (c == 0) eg = 2'd0;
      else if (eb) eg = ID_W'((c / 5) % 4);
      else eg = ID_W'(((c / 5) - 1) % 4);
      obs  = {o_busy, fifo_wren, o_grant_id};
      expv = {eb, eb, eg};
      n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL sat_c%0d: busy/wren/gid got %b want %b", c, obs, expv); end
      if (eb) begin
        ep = 32'h100 * eg + 32'(((c / 5) / 4) * 4 + (c % 5) - 1);
        n_vec++;
        if (fifo_wrdata !== {eg, ep}) begin
          n_err++; $display("FAIL sat_data_c%0d: got %h want %h", c, fifo_wrdata, {eg, ep});
        end
      end
      step();
    end
    s_valid = '0;
  endtask

  task automatic test_drop_valid();
    logic [9:0]      busy_v, wren_v;
    logic [ID_W-1:0] eg;
    logic [ID_W+1:0] obs, expv;
    logic [31:0]     ep;
    busy_v = 10'h1EE;
    wren_v = 10'h1E6;
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h0;
    base[1] = 32'h1000;
    base[2] = 32'h2000;
    reset_all();
    s_valid = 4'b0110;
    fifo_rd = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      eg   = (c == 0) ? 2'd0 : (c < 5) ? 2'd1 : 2'd2;
      obs  = {o_busy, fifo_wren, o_grant_id};
      expv = {busy_v[c], wren_v[c], eg};
      n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL drop_c%0d: busy/wren/gid got %b want %b", c, obs, expv); end
      if (wren_v[c]) begin
        ep = (c < 5) ? 32'h1000 + 32'(c - 1) : 32'h2000 + 32'(c - 5);
        n_vec++;
        if (fifo_wrdata !== {eg, ep}) begin
          n_err++; $display("FAIL drop_data_c%0d: got %h want %h", c, fifo_wrdata, {eg, ep});
        end
      end
      step();
      if (cnt[1] == 2) s_valid[1] = 1'b0;
    end
    s_valid = '0;
  endtask

  task automatic test_fifo_full();
    logic [18:0]      busy_v, wren_v, rd_v;
    logic [ID_W-1:0]  eg;
    logic [N_REQ+ID_W+1:0] obs, expv;
    int               nw;
    busy_v = 19'h3FBDE;
    wren_v = 19'h363DE;
    rd_v   = 19'h1B000;
    nw     = 0;
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h0;
    base[3] = 32'h300;
    reset_all();
    s_valid = 4'b1000;
    for (int c = 0; c < 19; c++) begin
      fifo_rd = rd_v[c];
      #1;
      eg   = (c == 0) ? 2'd0 : 2'd3;
      obs  = {o_busy, fifo_wren, s_ready, o_grant_id};
      expv = {busy_v[c], wren_v[c], wren_v[c] ? 4'b1000 : 4'b0000, eg};
      n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL full_c%0d: busy/wren/ready/gid got %b want %b", c, obs, expv); end
      if (wren_v[c]) begin
        n_vec++;
        if (fifo_wrdata !== {2'd3, 32'h300 + 32'(nw)}) begin
          n_err++; $display("FAIL full_data_c%0d: got %h want %h", c, fifo_wrdata, {2'd3, 32'h300 + 32'(nw)});
        end
        nw++;
      end
      step();
    end
    fifo_rd = 1'b0;
    s_valid = '0;
    #1;
    n_vec++;
    if (fq.size() != 8) begin n_err++; $display("FAIL full_count: got %0d want 8", fq.size()); end
    else begin
      n_vec++;
      if (fq[0] !== {2'd3, 32'h304} || fq[7] !== {2'd3, 32'h30B}) begin
        n_err++; $display("FAIL full_contents: got %h..%h want %h..%h", fq[0], fq[7], {2'd3, 32'h304}, {2'd3, 32'h30B});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [N_REQ+ID_W+1:0] obs;
    for (int i = 0; i < N_REQ; i++) base[i] = 32'h0;
    base[1] = 32'h5000;
    reset_all();
    s_valid = 4'b0010;
    fifo_rd = 1'b1;
    for (int c = 0; c < 3; c++) step();
    #1;
    n_vec++;
    if ({o_busy, o_grant_id} !== 3'b101) begin
      n_err++; $display("FAIL midrst_pre: busy/gid got %b want 101", {o_busy, o_grant_id});
    end
    rstn = 1'b0;
    step();
    #1;
    obs = {o_busy, fifo_wren, s_ready, o_grant_id};
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL midrst_after: busy/wren/ready/gid got %b want 0", obs); end
    rstn    = 1'b1;
    s_valid = 4'b1111;
    step();
    #1;
    n_vec++;
    if ({o_busy, o_grant_id} !== 3'b100) begin
      n_err++; $display("FAIL midrst_first_grant: busy/gid got %b want 100", {o_busy, o_grant_id});
    end
    s_valid = '0;
  endtask

  task automatic test_random();
    int            rx[N_REQ];
    int            total;
    int            cyc;
    logic [FW-1:0] pk;
    int            tag;
    for (int i = 0; i < N_REQ; i++) begin base[i] = 32'h0; rx[i] = 0; end
    reset_all();
    total = 0;
    cyc   = 0;
    while (total < 10000 && cyc < 50000) begin
      for (int i = 0; i < N_REQ; i++) s_valid[i] = ($urandom_range(0, 3) != 0);
      fifo_rd = ($urandom_range(0, 2) != 0);
      #1;
      n_vec++;
      if (fifo_wren && fifo_full) begin n_err++; $display("FAIL rnd_overflow: wren %b full %b", fifo_wren, fifo_full); end
      n_vec++;
      if (!$onehot0(s_ready)) begin n_err++; $display("FAIL rnd_onehot: ready %b", s_ready); end
      if (fifo_rd && fq.size() > 0) begin
        pk  = fq[0];
        tag = int'(pk[FW-1:DATA_W]);
        n_vec++;
        if (pk[DATA_W-1:0] !== 32'(rx[tag])) begin
          n_err++; $display("FAIL rnd_order src%0d: got %0d want %0d", tag, pk[DATA_W-1:0], rx[tag]);
        end
        rx[tag]++;
      end
      step();
      cyc++;
      total = 0;
      for (int i = 0; i < N_REQ; i++) total += cnt[i];
    end
    n_vec++;
    if (total < 10000) begin n_err++; $display("FAIL rnd_timeout: got %0d beats want 10000", total); end
    s_valid = '0;
    fifo_rd = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) begin
      #1;
      if (fq.size() > 0) begin
        pk  = fq[0];
        tag = int'(pk[FW-1:DATA_W]);
        n_vec++;
        if (pk[DATA_W-1:0] !== 32'(rx[tag])) begin
          n_err++; $display("FAIL rnd_drain src%0d: got %0d want %0d", tag, pk[DATA_W-1:0], rx[tag]);
        end
        rx[tag]++;
      end
      step();
    end
    for (int i = 0; i < N_REQ; i++) begin
      n_vec++;
      if (rx[i] != cnt[i]) begin n_err++; $display("FAIL rnd_total src%0d: got %0d want %0d", i, rx[i], cnt[i]); end
    end
    fifo_rd = 1'b0;
  endtask

  initial begin
    rstn     = 1'b0;
    s_valid  = '0;
    fifo_rd  = 1'b0;
    fifo_clr = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin base[i] = 32'h0; cnt[i] = 0; end
    drive_data();
    @(negedge clk);
    test_reset();
    test_single_requester();
    test_saturated();
    test_drop_valid();
    test_fifo_full();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
